sync_modn_counter: RTL and testbench

- Fully synchronous, parametrised mod-N up/down counter. It is the next-generation replacement for the ripple mod-10 counter.
- No derived clocks and no reset-feedback glitch path. All flops run on clk_i.
- Adds enable, direction, parallel load, synchronous clear, a cascade terminal-count output and a divided-clock output.
- Used as a BCD/decade digit, a general mod-N divider, or one stage of a cascaded multi-digit counter.

---
 rtl/sync_modn_counter.sv | 71 +++++++
 tb/tb_sync_modn_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_modn_counter.sv
// rtl/sync_modn_counter.sv - fully synchronous mod-N up/down counter with load, clear, cascade and divider outputs
module sync_modn_counter #(
   parameter int MOD      = 10,
   parameter int WIDTH    = $clog2(MOD),
   parameter bit DIV_MODE = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] q_o,
   output logic             tc_o,
   output logic             div_o
);

   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;

   logic             at_end;
   logic             wrap;
   logic             load_in_range;
   logic [WIDTH-1:0] q_next;

   // Terminal position depends on direction; wrap only when a plain count step commits it
   always_comb begin
      at_end        = up_i ? (q_o == MAX_VAL) : (q_o == ZERO_VAL);
      tc_o          = en_i & at_end;
      wrap          = en_i & at_end & ~clr_i & ~load_i;
      load_in_range = (32'(load_val_i) < 32'(MOD));
   end

   // Next count: clear beats load beats count; out-of-range loads saturate at MOD-1
   always_comb begin
      q_next = q_o;
      if (clr_i) begin
         q_next = ZERO_VAL;
      end else if (load_i) begin
         q_next = load_in_range ? load_val_i : MAX_VAL;
      end else if (en_i) begin
         if (up_i) begin
            q_next = at_end ? ZERO_VAL : q_o + WIDTH'(1);
         end else begin
            q_next = at_end ? MAX_VAL : q_o - WIDTH'(1);
         end
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_o <= ZERO_VAL;
      end else begin
         q_o <= q_next;
      end
   end

   // Divided output: toggle per wrap (square wave) or one-cycle pulse per wrap
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_o <= 1'b0;
      end else if (DIV_MODE) begin
         div_o <= wrap;
      end else if (wrap) begin
         div_o <= ~div_o;
      end
   end

endmodule

// File: tb/tb_sync_modn_counter.sv
// tb/tb_sync_modn_counter.sv - self-checking bench for sync_modn_counter
module tb_sync_modn_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
   logic [3:0] ld_val = '0;
   logic [3:0] q;
   logic       tc, div;

   logic       casc_en = 1'b0;
   logic [3:0] c0_q, c1_q;
   logic       c0_tc, c1_tc, c0_div, c1_div;

   logic       sweep_en = 1'b0;
   logic [0:0] s2_q;
   logic [2:0] s7_q;
   logic [3:0] s16_q;
   logic       s2_tc, s7_tc, s16_tc, s2_div, s7_div, s16_div;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural models
   int m_q = 0;
   bit m_div = 1'b0;
   int casc_n = 0;
   int sw_n = 0;
   bit p2 = 1'b0, p7 = 1'b0, p16 = 1'b0;

   always #5 clk = ~clk;

   sync_modn_counter #(.MOD(10), .DIV_MODE(1'b0)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
      .load_val_i(ld_val), .q_o(q), .tc_o(tc), .div_o(div));

   sync_modn_counter #(.MOD(10), .DIV_MODE(1'b0)) u_c0 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(casc_en), .up_i(1'b1), .clr_i(1'b0), .load_i(1'b0),
      .load_val_i(4'd0), .q_o(c0_q), .tc_o(c0_tc), .div_o(c0_div));

   sync_modn_counter #(.MOD(10), .DIV_MODE(1'b0)) u_c1 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(c0_tc), .up_i(1'b1), .clr_i(1'b0), .load_i(1'b0),
      .load_val_i(4'd0), .q_o(c1_q), .tc_o(c1_tc), .div_o(c1_div));

   sync_modn_counter #(.MOD(2), .DIV_MODE(1'b1)) u_s2 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(sweep_en), .up_i(1'b1), .clr_i(1'b0), .load_i(1'b0),
      .load_val_i(1'b0), .q_o(s2_q), .tc_o(s2_tc), .div_o(s2_div));

   sync_modn_counter #(.MOD(7), .DIV_MODE(1'b1)) u_s7 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(sweep_en), .up_i(1'b1), .clr_i(1'b0), .load_i(1'b0),
      .load_val_i(3'd0), .q_o(s7_q), .tc_o(s7_tc), .div_o(s7_div));

   sync_modn_counter #(.MOD(16), .DIV_MODE(1'b1)) u_s16 (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(sweep_en), .up_i(1'b1), .clr_i(1'b0), .load_i(1'b0),
      .load_val_i(4'd0), .q_o(s16_q), .tc_o(s16_tc), .div_o(s16_div));

   function automatic int step_val(input int cur, input int m, input bit dir_up);
      return dir_up ? (cur + 1) % m : (cur + m - 1) % m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model advance on each clock edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= 0; m_div <= 1'b0; casc_n <= 0; sw_n <= 0;
         p2 <= 1'b0; p7 <= 1'b0; p16 <= 1'b0;
      end else begin
         if (clr) m_q <= 0;
         else if (load) m_q <= (int'(ld_val) < 10) ? int'(ld_val) : 9;
         else if (en) begin
            m_q <= step_val(m_q, 10, up);
            if (step_val(m_q, 10, up) == (up ? 0 : 9)) m_div <= ~m_div;
         end
         if (casc_en) casc_n <= casc_n + 1;
         if (sweep_en) sw_n <= sw_n + 1;
         p2  <= sweep_en && ((sw_n + 1) % 2 == 0);
         p7  <= sweep_en && ((sw_n + 1) % 7 == 0);
         p16 <= sweep_en && ((sw_n + 1) % 16 == 0);
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      check("q", q, m_q);
      check("tc", tc, en && (up ? m_q == 9 : m_q == 0));
      check("div", div, m_div);
      check("c0_q", c0_q, casc_n % 10);
      check("c1_q", c1_q, (casc_n / 10) % 10);
      check("c0_div", c0_div, (casc_n / 10) % 2);
      check("c1_div", c1_div, (casc_n / 100) % 2);
      check("c1_tc", c1_tc, casc_en && (casc_n % 100 == 99));
      check("s2_q", s2_q, sw_n % 2);
      check("s7_q", s7_q, sw_n % 7);
      check("s16_q", s16_q, sw_n % 16);
      check("s7_lt_mod", s7_q < 3'd7, 1);
      check("s7_tc", s7_tc, sweep_en && (sw_n % 7 == 6));
      check("s2_div", s2_div, p2);
      check("s7_div", s7_div, p7);
      check("s16_div", s16_div, p16);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic u, input logic c, input logic l, input logic [3:0] v);
      en = e; up = u; clr = c; load = l; ld_val = v;
   endtask

   task automatic step(input logic e, input logic u, input logic c, input logic l, input logic [3:0] v);
      drive(e, u, c, l, v);
      tick();
   endtask

   int exp_down[5] = '{2, 1, 0, 9, 8};
   int exp_up[3]   = '{9, 0, 1};
   int exp_gate[5] = '{9, 9, 9, 0, 1};
   bit gate_en[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset and free-run
      repeat (2) tick();
      check("reset_q", q, 0);
      check("reset_div", div, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
      check("pre_rst_q", q, 2);
      check("pre_rst_div", div, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q", q, 0);
      check("async_rst_div", div, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         step(1, 1, 0, 0, 0);
         if (i == 9) begin
            check("run_q9", q, 9);
            check("run_tc9", tc, 1);
         end
         if (i == 10) begin
            check("run_q10", q, 0);
            check("run_div10", div, 1);
         end
         if (i == 20) check("run_div20", div, 0);
      end
      check("run_q25", q, 5);

      // down count then direction change
      step(0, 1, 0, 1, 4'd3);
      check("load3", q, 3);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0);
         check("down_seq", q, exp_down[i]);
         if (exp_down[i] == 0) check("down_tc0", tc, 1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, 0);
         check("up_seq", q, exp_up[i]);
         if (exp_up[i] == 9) check("up_tc9", tc, 1);
      end

      // priority and clamp, div must survive clr/load
      step(0, 1, 0, 1, 4'd9);
      step(1, 1, 0, 0, 0);
      check("prio_setup_div", div, 1);
      step(0, 1, 0, 1, 4'd12);
      check("clamp12", q, 9);
      step(1, 1, 1, 1, 4'd7);
      check("clr_wins", q, 0);
      step(1, 1, 0, 1, 4'd5);
      check("load_beats_en", q, 5);
      check("prio_div_kept", div, 1);
      step(0, 1, 0, 1, 4'd15);
      check("clamp15", q, 9);

      // enable gating from 8
      step(0, 1, 0, 1, 4'd8);
      for (int i = 0; i < 5; i++) begin
         drive(gate_en[i], 1, 0, 0, 0);
         #1;
         if (!gate_en[i] && q == 4'd9) check("gate_tc_low", tc, 0);
         tick();
         check("gate_seq", q, exp_gate[i]);
      end
      drive(0, 1, 0, 0, 0);

      // two-digit cascade, 105 counts
      casc_en = 1'b1;
      repeat (105) tick();
      casc_en = 1'b0;
      check("casc_d0", c0_q, 5);
      check("casc_d1", c1_q, 0);
      check("casc_d1_div", c1_div, 1);

      // DIV_MODE 1 sweep, 48 counts
      sweep_en = 1'b1;
      repeat (48) tick();
      check("sw2_q", s2_q, 0);
      check("sw2_div", s2_div, 1);
      check("sw7_q", s7_q, 6);
      check("sw7_div", s7_div, 0);
      check("sw16_q", s16_q, 0);
      check("sw16_div", s16_div, 1);
      tick();
      check("sw16_pulse_end", s16_div, 0);
      check("sw16_q1", s16_q, 1);
      sweep_en = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
